// File: rtl/fpc_rr_mux_n.sv
// fpc_rr_mux_n
// Read-request multiplexer for the FPGA-to-PC DMA path. NCH channels are
// arbitrated round-robin. Each request's page is translated through a
// per-channel page table held in block RAM and loaded over PIO. One
// translated, tagged read request is issued at a time.
//
// state | meaning
// ------+--------------------------------------------------------------
// ARB   | scan channels after last_ch and latch the first requester
// RD    | page-table RAM output register loads {ch, page} entry
// CHK   | valid entry -> build address/tag; invalid -> fault, consume
// ISSUE | rrm_valid held until rrm_ready; rr_ready[ch] follows rrm_ready
//
// Ports:
//   clock, reset_n         system clock, async active-low reset
//   pio_wvalid/wdata/addr  page-table write port
//                          (wdata[63:PAGE_LOG2] base, wdata[0] valid)
//   rr_valid/rr_ready      per-channel request handshake
//                          (rr_ready is a one-hot pulse)
//   rr_addr                channel c address at [64c+63:64c]
//   rrm_valid/ready        multiplexed request handshake
//   rrm_addr/rrm_tag       translated address and tag {0, ch, la[2:0]}
//   fault_valid/chan/page  one-cycle report of a hit on an invalid entry
//   fault_count            saturating count of faults
module fpc_rr_mux_n #(
  parameter  int NCH       = 4,
  parameter  int PT_LOG2   = 5,
  parameter  int PAGE_LOG2 = 21,
  parameter  int REQ_LOG2  = 9,
  parameter  int PIO_SEL   = 1,
  localparam int CBITS     = $clog2(NCH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pio_wvalid,
  input  logic [63:0]          pio_wdata,
  input  logic [12:0]          pio_addr,
  input  logic [NCH-1:0]       rr_valid,
  output logic [NCH-1:0]       rr_ready,
  input  logic [64*NCH-1:0]    rr_addr,
  output logic                 rrm_valid,
  output logic [63:0]          rrm_addr,
  output logic [7:0]           rrm_tag,
  input  logic                 rrm_ready,
  output logic                 fault_valid,
  output logic [CBITS-1:0]     fault_chan,
  output logic [PT_LOG2-1:0]   fault_page,
  output logic [15:0]          fault_count
);

  localparam int AW = CBITS + PT_LOG2;      // page-table address width
  localparam int BW = 64 - PAGE_LOG2;       // page base width
  localparam int EW = BW + 1;               // entry: {base, valid}
  localparam int LW = PAGE_LOG2 - REQ_LOG2; // request index within a page
  localparam int SW = 13 - AW;              // PIO select field width

  typedef enum logic [1:0] {ST_ARB, ST_RD, ST_CHK, ST_ISSUE} state_t;

  state_t             state_q, state_d;
  logic [CBITS-1:0]   last_ch_q, last_ch_d;
  logic [CBITS-1:0]   ch_q, ch_d;
  logic [PT_LOG2-1:0] page_q, page_d;
  logic [LW-1:0]      la_q, la_d;
  logic [63:0]        rrm_addr_q, rrm_addr_d;
  logic [7:0]         rrm_tag_q, rrm_tag_d;
  logic               fault_valid_q, fault_valid_d;
  logic [CBITS-1:0]   fault_chan_q, fault_chan_d;
  logic [PT_LOG2-1:0] fault_page_q, fault_page_d;
  logic [15:0]        fault_count_q, fault_count_d;

  logic [EW-1:0]      pt_mem [2**AW];
  logic [EW-1:0]      pt_rdata_q;
  logic               pt_rd_en;
  logic               pio_we;

  logic [63:0]        ch_addr [NCH];
  logic               pick_found;
  logic [CBITS-1:0]   pick_ch;
  logic [CBITS-1:0]   cand;
  logic [63:0]        pick_addr;

  for (genvar g = 0; g < NCH; g++) begin : g_split
    assign ch_addr[g] = rr_addr[64*g +: 64];
  end

  assign pio_we = pio_wvalid && (pio_addr[12:AW] == SW'(PIO_SEL));

  // Page-table RAM, read-first: a write and a read of the same entry in one
  // cycle return the old contents. Not reset.
  always_ff @(posedge clock) begin
    if (pio_we) begin
      pt_mem[pio_addr[AW-1:0]] <= {pio_wdata[63:PAGE_LOG2], pio_wdata[0]};
    end
    if (pt_rd_en) begin
      pt_rdata_q <= pt_mem[{ch_q, page_q}];
    end
  end

  // All NCH candidates are examined in one cycle, starting just after the
  // last channel served, so idle channels cost no extra cycles.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CBITS'((int'(last_ch_q) + i) % NCH);
      if (!pick_found && rr_valid[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  assign pick_addr = ch_addr[pick_ch];

  always_comb begin
    state_d       = state_q;
    last_ch_d     = last_ch_q;
    ch_d          = ch_q;
    page_d        = page_q;
    la_d          = la_q;
    rrm_addr_d    = rrm_addr_q;
    rrm_tag_d     = rrm_tag_q;
    fault_valid_d = 1'b0;
    fault_chan_d  = fault_chan_q;
    fault_page_d  = fault_page_q;
    fault_count_d = fault_count_q;
    rr_ready      = '0;
    pt_rd_en      = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          ch_d      = pick_ch;
          last_ch_d = pick_ch;
          page_d    = pick_addr[PAGE_LOG2+PT_LOG2-1:PAGE_LOG2];
          la_d      = pick_addr[PAGE_LOG2-1:REQ_LOG2];
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        pt_rd_en = 1'b1;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        if (pt_rdata_q[0]) begin
          rrm_addr_d = {pt_rdata_q[EW-1:1], la_q, {REQ_LOG2{1'b0}}};
          rrm_tag_d  = {{(8-CBITS-3){1'b0}}, ch_q, la_q[2:0]};
          state_d    = ST_ISSUE;
        end else begin
          // Invalid entry: report it and consume the request so the
          // channel does not retry a translation that can never succeed.
          fault_valid_d = 1'b1;
          fault_chan_d  = ch_q;
          fault_page_d  = page_q;
          if (fault_count_q != 16'hFFFF) begin
            fault_count_d = fault_count_q + 16'd1;
          end
          rr_ready[ch_q] = 1'b1;
          state_d        = ST_ARB;
        end
      end
      ST_ISSUE: begin
        if (rrm_ready) begin
          rr_ready[ch_q] = 1'b1;
          state_d        = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ARB;
      last_ch_q     <= CBITS'(NCH - 1);
      ch_q          <= '0;
      page_q        <= '0;
      la_q          <= '0;
      rrm_addr_q    <= '0;
      rrm_tag_q     <= '0;
      fault_valid_q <= 1'b0;
      fault_chan_q  <= '0;
      fault_page_q  <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      last_ch_q     <= last_ch_d;
      ch_q          <= ch_d;
      page_q        <= page_d;
      la_q          <= la_d;
      rrm_addr_q    <= rrm_addr_d;
      rrm_tag_q     <= rrm_tag_d;
      fault_valid_q <= fault_valid_d;
      fault_chan_q  <= fault_chan_d;
      fault_page_q  <= fault_page_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign rrm_valid   = (state_q == ST_ISSUE);
  assign rrm_addr    = rrm_addr_q;
  assign rrm_tag     = rrm_tag_q;
  assign fault_valid = fault_valid_q;
  assign fault_chan  = fault_chan_q;
  assign fault_page  = fault_page_q;
  assign fault_count = fault_count_q;

  // Address bits outside the page and request-index fields are don't-care.
  logic unused_bits;
  assign unused_bits = ^{pio_wdata[PAGE_LOG2-1:1],
                         pick_addr[63:PAGE_LOG2+PT_LOG2],
                         pick_addr[REQ_LOG2-1:0]};

endmodule

// File: tb/tb_fpc_rr_mux_n.sv
module tb_fpc_rr_mux_n;

  localparam int NCH       = 4;
  localparam int CBITS     = 2;
  localparam int PT_LOG2   = 5;
  localparam int PAGE_LOG2 = 21;
  localparam int REQ_LOG2  = 9;
  localparam int PIO_SEL   = 1;
  localparam int NPG       = 32;

  logic               clock;
  logic               reset_n;
  logic               pio_wvalid;
  logic [63:0]        pio_wdata;
  logic [12:0]        pio_addr;
  logic [NCH-1:0]     rr_valid;
  logic [NCH-1:0]     rr_ready;
  logic [64*NCH-1:0]  rr_addr;
  logic               rrm_valid;
  logic [63:0]        rrm_addr;
  logic [7:0]         rrm_tag;
  logic               rrm_ready;
  logic               fault_valid;
  logic [CBITS-1:0]   fault_chan;
  logic [PT_LOG2-1:0] fault_page;
  logic [15:0]        fault_count;

  logic [63:0] rr_addr_a [NCH];
  logic [63:0] sh_word [NCH][NPG];

  int total;
  int bad;

  fpc_rr_mux_n #(
    .NCH(NCH), .PT_LOG2(PT_LOG2), .PAGE_LOG2(PAGE_LOG2),
    .REQ_LOG2(REQ_LOG2), .PIO_SEL(PIO_SEL)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .pio_wvalid(pio_wvalid), .pio_wdata(pio_wdata), .pio_addr(pio_addr),
    .rr_valid(rr_valid), .rr_ready(rr_ready), .rr_addr(rr_addr),
    .rrm_valid(rrm_valid), .rrm_addr(rrm_addr), .rrm_tag(rrm_tag),
    .rrm_ready(rrm_ready),
    .fault_valid(fault_valid), .fault_chan(fault_chan),
    .fault_page(fault_page), .fault_count(fault_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    rr_addr = '0;
    for (int c = 0; c < NCH; c++) rr_addr[64*c +: 64] = rr_addr_a[c];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pt_write(input int ch, input int pg, input logic [63:0] w);
    pio_wvalid = 1'b1;
    pio_wdata  = w;
    pio_addr   = 13'((PIO_SEL << 7) | (ch << 5) | pg);
    tick();
    pio_wvalid = 1'b0;
    sh_word[ch][pg] = w;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pio_wvalid = 1'b0;
    pio_wdata  = '0;
    pio_addr   = '0;
    rr_valid   = '0;
    rrm_ready  = 1'b0;
    for (int c = 0; c < NCH; c++) rr_addr_a[c] = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // Reference model: translation is the stored base with the request's
  // offset inside the page, truncated to request granularity.
  function automatic int page_of(input logic [63:0] a);
    return int'((a >> PAGE_LOG2) & 64'h1F);
  endfunction

  function automatic logic [63:0] exp_addr(input int ch, input logic [63:0] a);
    logic [63:0] w;
    w = sh_word[ch][page_of(a)];
    return (w & ~64'h1F_FFFF) | (a & 64'h1F_FE00);
  endfunction

  function automatic logic [7:0] exp_tag(input int ch, input logic [63:0] a);
    return 8'(ch * 8 + int'((a >> REQ_LOG2) & 64'h7));
  endfunction

  function automatic logic exp_ok(input int ch, input logic [63:0] a);
    logic [63:0] w;
    w = sh_word[ch][page_of(a)];
    return w[0];
  endfunction

  // Round-robin rule: first requester strictly after the last one served.
  function automatic int model_pick(input int last, input logic [NCH-1:0] m);
    for (int i = 1; i <= NCH; i++) begin
      if (m[(last + i) % NCH]) return (last + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [63:0] make_addr(input int pg);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[25:21] = 5'(pg);
    return a;
  endfunction

  function automatic logic [63:0] valid_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[0] = 1'b1;
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if ({rrm_valid, rr_ready, fault_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b ready=%b fault=%b want 0 0000 0",
               rrm_valid, rr_ready, fault_valid);
    end
    total++;
    if (fault_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_fault_count: got %0d want 0", fault_count);
    end
    tick();
    tick();
    total++;
    if ({rrm_valid, rr_ready} !== 5'b0) begin
      bad++;
      $display("FAIL idle_no_request: got valid=%b ready=%b want 0", rrm_valid, rr_ready);
    end
  endtask

  task automatic test_basic();
    pt_write(1, 3, 64'h0000_0012_3460_0001);
    // A write outside the page-table window must not touch the entry.
    pio_wvalid = 1'b1;
    pio_wdata  = '1;
    pio_addr   = 13'((2 << 7) | (1 << 5) | 3);
    tick();
    pio_wvalid = 1'b0;
    rr_addr_a[1] = 64'h0060_0A00;
    rr_valid     = 4'b0010;
    tick();
    tick();
    total++;
    if (rrm_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid: got %b want 0 two cycles after request", rrm_valid);
    end
    tick();
    total++;
    if (rrm_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: got rrm_valid=%b want 1 three cycles after request", rrm_valid);
    end
    total++;
    if (rrm_addr !== 64'h0000_0012_3460_0A00) begin
      bad++;
      $display("FAIL basic_addr: got %h want 0000001234600a00", rrm_addr);
    end
    total++;
    if (rrm_tag !== 8'h0D) begin
      bad++;
      $display("FAIL basic_tag: got %h want 0d", rrm_tag);
    end
    total++;
    if (rr_ready !== 4'b0000) begin
      bad++;
      $display("FAIL basic_ready_early: got %b want 0000", rr_ready);
    end
    rrm_ready = 1'b1;
    #1;
    total++;
    if (rr_ready !== 4'b0010) begin
      bad++;
      $display("FAIL basic_ready: got %b want 0010", rr_ready);
    end
    tick();
    rr_valid  = '0;
    rrm_ready = 1'b0;
    total++;
    if (rrm_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_handshake: got rrm_valid=%b want 0", rrm_valid);
    end
  endtask

  task automatic test_round_robin();
    int last, n, prev, ec;
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      pt_write(c, c + 4, valid_word());
      rr_addr_a[c] = make_addr(c + 4);
    end
    rr_valid  = '1;
    rrm_ready = 1'b1;
    last = NCH - 1;
    n    = 0;
    prev = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick();
      if (rrm_valid === 1'b1) begin
        ec = model_pick(last, rr_valid);
        total++;
        if (rrm_tag[4:3] !== 2'(ec) || rr_ready !== 4'(1 << ec)) begin
          bad++;
          $display("FAIL rr_order: grant %0d got ch=%0d ready=%b want ch=%0d", n, rrm_tag[4:3], rr_ready, ec);
        end
        total++;
        if (rrm_addr !== exp_addr(ec, rr_addr_a[ec])) begin
          bad++;
          $display("FAIL rr_addr: grant %0d got %h want %h", n, rrm_addr, exp_addr(ec, rr_addr_a[ec]));
        end
        total++;
        if ((n == 0 && cyc != 3) || (n != 0 && cyc - prev != 4)) begin
          bad++;
          $display("FAIL rr_spacing: grant %0d at cycle %0d prev %0d want first 3 then every 4", n, cyc, prev);
        end
        prev = cyc;
        last = ec;
        n++;
        if (n == 5) break;
      end
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL rr_count: got %0d grants want 5", n);
    end
    rr_valid = '0;
    tick();
    rrm_ready = 1'b0;
  endtask

  task automatic test_idle_skip();
    int k;
    do_reset();
    pt_write(3, 1, valid_word());
    rr_addr_a[3] = make_addr(1);
    rr_valid = 4'b1000;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rrm_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    total++;
    if (k != 3 || rrm_tag[4:3] !== 2'd3) begin
      bad++;
      $display("FAIL idle_skip: got valid at cycle %0d ch=%0d want cycle 3 ch=3", k, rrm_tag[4:3]);
    end
    rrm_ready = 1'b1;
    tick();
    rrm_ready = 1'b0;
    rr_valid  = '0;
  endtask

  task automatic test_fault();
    int rdy_n, flt_n;
    logic seen_valid;
    do_reset();
    pt_write(2, 7, 64'hABCD_0000_0000_0000);
    rr_addr_a[2] = make_addr(7);
    rr_valid = 4'b0100;
    rdy_n = 0;
    flt_n = 0;
    seen_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rr_ready !== 4'b0000) begin
        rdy_n++;
        total++;
        if (rr_ready !== 4'b0100) begin
          bad++;
          $display("FAIL fault_ready: got %b want 0100", rr_ready);
        end
        rr_valid = '0;
      end
      if (fault_valid === 1'b1) begin
        flt_n++;
        total++;
        if (fault_chan !== 2'd2 || fault_page !== 5'd7) begin
          bad++;
          $display("FAIL fault_info: got chan=%0d page=%0d want chan=2 page=7", fault_chan, fault_page);
        end
      end
      if (rrm_valid === 1'b1) seen_valid = 1'b1;
    end
    total++;
    if (flt_n != 1 || rdy_n != 1) begin
      bad++;
      $display("FAIL fault_pulses: got fault=%0d ready=%0d pulses want 1 1", flt_n, rdy_n);
    end
    total++;
    if (seen_valid !== 1'b0) begin
      bad++;
      $display("FAIL fault_no_issue: got rrm_valid seen=%b want 0", seen_valid);
    end
    total++;
    if (fault_count !== 16'd1) begin
      bad++;
      $display("FAIL fault_count: got %0d want 1", fault_count);
    end
  endtask

  task automatic test_stall();
    logic [63:0] ea;
    logic [7:0]  et;
    logic        got;
    pt_write(0, 9, valid_word());
    rr_addr_a[0] = make_addr(9);
    ea = exp_addr(0, rr_addr_a[0]);
    et = exp_tag(0, rr_addr_a[0]);
    rr_valid = 4'b0001;
    got = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rrm_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout: got no rrm_valid within 10 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({rrm_valid, rrm_addr, rrm_tag, rr_ready} !== {1'b1, ea, et, 4'b0000}) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d got v=%b a=%h t=%h r=%b want 1 %h %h 0000",
                 i, rrm_valid, rrm_addr, rrm_tag, rr_ready, ea, et);
      end
      tick();
    end
    rrm_ready = 1'b1;
    #1;
    total++;
    if (rr_ready !== 4'b0001) begin
      bad++;
      $display("FAIL stall_release: got %b want 0001", rr_ready);
    end
    tick();
    rrm_ready = 1'b0;
    rr_valid  = '0;
    total++;
    if ({rrm_valid, rr_ready} !== 5'b0) begin
      bad++;
      $display("FAIL stall_single_pulse: got v=%b r=%b want 0 0000", rrm_valid, rr_ready);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    pt_write(2, 1, valid_word());
    rr_addr_a[2] = make_addr(1);
    rr_addr_a[0] = make_addr(9);
    rr_addr_a[3] = make_addr(1);
    rr_valid = 4'b0100;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rrm_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    total++;
    if (k != 3 || fault_count !== 16'd1) begin
      bad++;
      $display("FAIL midrst_setup: got valid cycle=%0d count=%0d want 3 1", k, fault_count);
    end
    rr_valid = 4'b1101;
    #3;
    rrm_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    total++;
    if ({rrm_valid, rr_ready} !== 5'b0 || fault_count !== 16'd0) begin
      bad++;
      $display("FAIL midrst_abort: got v=%b r=%b count=%0d want 0 0000 0", rrm_valid, rr_ready, fault_count);
    end
    rrm_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rrm_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    total++;
    if (k != 3 || rrm_tag[4:3] !== 2'(model_pick(NCH - 1, rr_valid))) begin
      bad++;
      $display("FAIL midrst_priority: got cycle=%0d ch=%0d want cycle 3 ch=0", k, rrm_tag[4:3]);
    end
    rrm_ready = 1'b1;
    tick();
    rrm_ready = 1'b0;
    rr_valid  = '0;
  endtask

  task automatic test_random();
    int last, fcnt, ec, pg, hit;
    logic [63:0] a;
    logic ok;
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < NPG; p++) begin
        a = {$urandom, $urandom};
        a[0] = ($urandom_range(0, 3) != 0);
        pt_write(c, p, a);
      end
    end
    last = NCH - 1;
    fcnt = 0;
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        rr_addr_a[c] = {$urandom, $urandom};
        rr_valid[c]  = 1'b1;
      end
    end
    for (int it = 0; it < 60; it++) begin
      if (rr_valid == '0) begin
        ec = $urandom_range(0, NCH - 1);
        rr_addr_a[ec] = {$urandom, $urandom};
        rr_valid[ec]  = 1'b1;
      end
      ec = model_pick(last, rr_valid);
      a  = rr_addr_a[ec];
      pg = page_of(a);
      ok = exp_ok(ec, a);
      hit = -1;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (rrm_valid === 1'b1 || rr_ready !== 4'b0000) begin
          hit = k;
          break;
        end
      end
      total++;
      if (hit != (ok ? 2 : 1)) begin
        bad++;
        $display("FAIL rand_latency: iter %0d got event at %0d want %0d", it, hit, ok ? 2 : 1);
        do_reset();
        return;
      end
      if (ok) begin
        total++;
        if ({rrm_valid, rrm_addr, rrm_tag} !== {1'b1, exp_addr(ec, a), exp_tag(ec, a)}) begin
          bad++;
          $display("FAIL rand_issue: iter %0d got v=%b a=%h t=%h want 1 %h %h",
                   it, rrm_valid, rrm_addr, rrm_tag, exp_addr(ec, a), exp_tag(ec, a));
        end
        repeat ($urandom_range(0, 3)) tick();
        rrm_ready = 1'b1;
        #1;
        total++;
        if (rr_ready !== 4'(1 << ec)) begin
          bad++;
          $display("FAIL rand_ready: iter %0d got %b want %b", it, rr_ready, 4'(1 << ec));
        end
        tick();
        rrm_ready   = 1'b0;
        rr_valid[ec] = 1'b0;
      end else begin
        total++;
        if (rr_ready !== 4'(1 << ec) || rrm_valid !== 1'b0) begin
          bad++;
          $display("FAIL rand_fault_ready: iter %0d got r=%b v=%b want %b 0", it, rr_ready, rrm_valid, 4'(1 << ec));
        end
        rr_valid[ec] = 1'b0;
        tick();
        fcnt++;
        total++;
        if ({fault_valid, fault_chan, fault_page, fault_count} !== {1'b1, 2'(ec), 5'(pg), 16'(fcnt)}) begin
          bad++;
          $display("FAIL rand_fault: iter %0d got f=%b ch=%0d pg=%0d cnt=%0d want 1 %0d %0d %0d",
                   it, fault_valid, fault_chan, fault_page, fault_count, ec, pg, fcnt);
        end
      end
      last = ec;
      if ($urandom_range(0, 9) < 6) begin
        rr_addr_a[ec] = {$urandom, $urandom};
        rr_valid[ec]  = 1'b1;
      end
    end
    rr_valid = '0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n    = 1'b0;
    pio_wvalid = 1'b0;
    pio_wdata  = '0;
    pio_addr   = '0;
    rr_valid   = '0;
    rrm_ready  = 1'b0;
    for (int c = 0; c < NCH; c++) rr_addr_a[c] = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_idle_skip();
    test_fault();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
